// File: rtl/can_fmt_pkg.sv
// Shared definitions for the CAN-receive-to-ASCII formatter: character codes,
// FSM encoding, FIFO entry layout and the nibble-to-hex helper.
package can_fmt_pkg;

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_BANG  = 8'h21;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TYPE,
        ST_ID,
        ST_COLON,
        ST_DHI,
        ST_DLO,
        ST_NEXT,
        ST_ABORT,
        ST_CR,
        ST_LF
    } state_t;

    typedef struct packed {
        logic        first;
        logic        last;
        logic        ide;
        logic [28:0] id;
        logic [7:0]  data;
    } entry_t;

    // Derived from the field layout so the FIFO width can never drift from it.
    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [7:0] hex2asc(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/can_rx_fifo.sv
// Single-clock FIFO with registered read data, valid the cycle after a pop.
// A write while full is accepted only when a pop happens in the same cycle.
module can_rx_fifo #(
    parameter int WIDTH   = 40,
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]  rd_data_q;
    logic              do_rd, do_wr;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign do_rd   = rd_en_i && !empty_o;
    assign do_wr   = wr_en_i && (!full_o || do_rd);

    assign wr_ptr_d  = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign rd_data_o = rd_data_q;

    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_rd) begin
                rd_data_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
            end
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/can_rx_hex_formatter.sv
// Turns the CAN controller's received-byte stream into one ASCII line per frame
// ("S123:0A0B\r\n") and streams it to the UART over a valid/ready interface.
module can_rx_hex_formatter
    import can_fmt_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int CNT_W   = 16
) (
    input  logic             rstn,
    input  logic             clk,
    input  logic             rx_valid,
    input  logic             rx_last,
    input  logic [7:0]       rx_data,
    input  logic [28:0]      rx_id,
    input  logic             rx_ide,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [7:0]       o_tdata,
    output logic [CNT_W-1:0] drop_cnt
);

    state_t            state_q, state_d, cur, nxt;
    logic [2:0]        cnt_q, cnt_d, cnt_nxt;
    logic              abort_q, abort_d, abort_nxt;
    logic              chk_q, chk_d;
    logic              tvalid_q, tvalid_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              first_flag_q;
    logic [CNT_W-1:0]  drop_q;

    logic              fifo_full, fifo_empty, pop, emit, out_free;
    logic [7:0]        chr;
    entry_t            wr_entry, entry;
    logic [31:0]       id32;
    logic [3:0]        nib;

    assign wr_entry = {first_flag_q, rx_last, rx_ide, rx_id, rx_data};

    can_rx_fifo #(
        .WIDTH   (ENTRY_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (rx_valid),
        .wr_data_i (wr_entry),
        .rd_en_i   (pop),
        .rd_data_o (entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign id32     = entry.ide ? {3'b000, entry.id} : {21'd0, entry.id[10:0]};
    assign nib      = id32[{cnt_q, 2'b00} +: 4];
    assign out_free = !tvalid_q || o_tready;
    assign o_tvalid = tvalid_q;
    assign o_tdata  = tdata_q;
    assign drop_cnt = drop_q;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        chk_d     = chk_q;
        tvalid_d  = tvalid_q & ~o_tready;
        tdata_d   = tdata_q;
        pop       = 1'b0;
        emit      = 1'b0;
        chr       = 8'h00;
        nxt       = state_q;
        cnt_nxt   = cnt_q;
        abort_nxt = abort_q;

        // An entry popped in NEXT becomes visible in DHI; a frame start there means
        // the previous frame was truncated, so the line is aborted instead.
        cur = (state_q == ST_DHI && chk_q && entry.first) ? ST_ABORT : state_q;

        case (cur)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (!entry.first) begin
                    state_d = ST_IDLE;
                end else begin
                    emit    = 1'b1;
                    chr     = entry.ide ? ASC_E : ASC_S;
                    cnt_nxt = entry.ide ? 3'd7 : 3'd2;
                    nxt     = ST_ID;
                end
            end
            ST_ID: begin
                emit    = 1'b1;
                chr     = hex2asc(nib);
                nxt     = (cnt_q == 3'd0) ? ST_COLON : ST_ID;
                cnt_nxt = cnt_q - 3'd1;
            end
            ST_COLON: begin
                emit = 1'b1;
                chr  = ASC_COLON;
                nxt  = ST_DHI;
            end
            ST_DHI: begin
                emit = 1'b1;
                chr  = hex2asc(entry.data[7:4]);
                nxt  = ST_DLO;
            end
            ST_DLO: begin
                emit = 1'b1;
                chr  = hex2asc(entry.data[3:0]);
                nxt  = entry.last ? ST_CR : ST_NEXT;
            end
            ST_NEXT: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DHI;
                    chk_d   = 1'b1;
                end
            end
            ST_ABORT: begin
                emit      = 1'b1;
                chr       = ASC_BANG;
                nxt       = ST_CR;
                abort_nxt = 1'b1;
            end
            ST_CR: begin
                emit = 1'b1;
                chr  = ASC_CR;
                nxt  = ST_LF;
            end
            ST_LF: begin
                emit      = 1'b1;
                chr       = ASC_LF;
                nxt       = abort_q ? ST_TYPE : ST_IDLE;
                abort_nxt = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit && out_free) begin
            tvalid_d = 1'b1;
            tdata_d  = chr;
            state_d  = nxt;
            cnt_d    = cnt_nxt;
            abort_d  = abort_nxt;
            chk_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            chk_q        <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 8'h00;
            first_flag_q <= 1'b1;
            drop_q       <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            chk_q    <= chk_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            if (rx_valid) begin
                first_flag_q <= rx_last;
            end
            if (rx_valid && fifo_full && !pop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_can_rx_hex_formatter.sv
// Scoreboard bench: stimulus pushes expected ASCII characters, a monitor pops
// and compares on every accepted character and checks stall stability.
module tb_can_rx_hex_formatter;

    localparam int CNT_W = 16;

    logic             rstn = 1'b0;
    logic             clk  = 1'b0;
    logic             rx_valid = 1'b0;
    logic             rx_last  = 1'b0;
    logic [7:0]       rx_data  = 8'h00;
    logic [28:0]      rx_id    = '0;
    logic             rx_ide   = 1'b0;
    logic             o_tvalid;
    logic             o_tready;
    logic [7:0]       o_tdata;
    logic [CNT_W-1:0] drop_cnt;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               ready_mode = 1;  // 0 = low, 1 = high, 2 = random
    logic [7:0]       exp_q[$];
    logic             stall_pend = 1'b0;
    logic [7:0]       stall_data = 8'h00;

    can_rx_hex_formatter #(
        .FIFO_AW (2),
        .CNT_W   (CNT_W)
    ) dut (
        .rstn     (rstn),
        .clk      (clk),
        .rx_valid (rx_valid),
        .rx_last  (rx_last),
        .rx_data  (rx_data),
        .rx_id    (rx_id),
        .rx_ide   (rx_ide),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input logic ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_crlf();
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // First byte in bits [63:56]; call at a point where the next edge should sample it.
    task automatic send_frame(input logic [28:0] id, input logic ide,
                              input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_id    = id;
            rx_ide   = ide;
            rx_data  = bytes[63-8*i -: 8];
            rx_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || o_tvalid) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
    endtask

    initial begin
        o_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       o_tready = 1'b0;
                1:       o_tready = 1'b1;
                default: o_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check(o_tvalid && o_tdata == stall_data, "stall_hold",
                      {23'd0, o_tvalid, o_tdata}, {23'd0, 1'b1, stall_data});
            end
            if (o_tvalid && o_tready) begin
                check(exp_q.size() != 0, "unexpected_char", o_tdata, 0);
                if (exp_q.size() != 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(o_tdata == e, "char", o_tdata, e);
                end
                stall_pend = 1'b0;
            end else if (o_tvalid) begin
                stall_pend = 1'b1;
                stall_data = o_tdata;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d chars pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        bit found;

        // Reset state
        repeat (2) @(negedge clk);
        check(o_tvalid == 1'b0, "rst_tvalid", o_tvalid, 0);
        check(o_tdata == 8'h00, "rst_tdata", o_tdata, 0);
        check(drop_cnt == '0, "rst_drop", drop_cnt, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Standard frame, back-to-back bytes, with first-character latency
        push_str("S123:00010203"); push_crlf();
        rx_id = 29'h123; rx_ide = 1'b0; rx_last = 1'b0;
        rx_valid = 1'b1; rx_data = 8'h00;
        @(posedge clk); #1;
        check(o_tvalid == 1'b0, "lat_edge_n", o_tvalid, 0);
        rx_data = 8'h01;
        @(posedge clk); #1;
        check(o_tvalid == 1'b0, "lat_edge_n1", o_tvalid, 0);
        rx_data = 8'h02;
        @(posedge clk); #1;
        check(o_tvalid == 1'b1 && o_tdata == 8'h53, "lat_edge_n2",
              {o_tvalid, o_tdata}, {1'b1, 8'h53});
        rx_data = 8'h03; rx_last = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_last = 1'b0;
        wait_drain("drain_std");
        check(drop_cnt == '0, "std_drop", drop_cnt, 0);

        // Extended frame: top nibble comes from zero-extended bit 28
        push_str("E12345678:AB"); push_crlf();
        send_frame(29'h12345678, 1'b1, 64'hAB00_0000_0000_0000, 1);
        wait_drain("drain_ext");

        // Same standard frame under random backpressure
        ready_mode = 2;
        push_str("S123:00010203"); push_crlf();
        send_frame(29'h123, 1'b0, 64'h0001_0203_0000_0000, 4);
        wait_drain("drain_rand");
        ready_mode = 1;
        @(posedge clk); #1;

        // Overflow: a short frame occupies the formatter while a 6-byte frame
        // lands in the 4-entry FIFO with the output stalled; 2 bytes are lost.
        ready_mode = 0;
        repeat (2) @(posedge clk); #1;
        push_str("S0AA:5A"); push_crlf();
        push_str("S7FF:11223344");
        send_frame(29'h0AA, 1'b0, 64'h5A00_0000_0000_0000, 1);
        send_frame(29'h7FF, 1'b0, 64'h1122_3344_5566_0000, 6);
        repeat (5) @(posedge clk); #1;
        check(drop_cnt == 16'd2, "ovf_drop", drop_cnt, 2);
        ready_mode = 1;
        wait_drain("drain_ovf");
        repeat (5) @(negedge clk);
        check(o_tvalid == 1'b0, "ovf_no_cr", o_tvalid, 0);
        check(drop_cnt == 16'd2, "ovf_drop_hold", drop_cnt, 2);
        @(posedge clk); #1;
        push_str("!"); push_crlf();
        push_str("S001:55"); push_crlf();
        send_frame(29'h001, 1'b0, 64'h5500_0000_0000_0000, 1);
        wait_drain("drain_abort");

        // Reset in the middle of a line
        push_str("S321:ABCD"); push_crlf();
        send_frame(29'h321, 1'b0, 64'hABCD_0000_0000_0000, 2);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (o_tvalid && o_tdata == 8'h41) found = 1'b1;
        end
        check(found, "reach_dlo", found, 1);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        check(o_tvalid == 1'b0, "midrst_tvalid", o_tvalid, 0);
        check(drop_cnt == '0, "midrst_drop", drop_cnt, 0);
        repeat (3) @(negedge clk);
        check(o_tvalid == 1'b0, "midrst_tvalid_hold", o_tvalid, 0);
        push_str("S456:10"); push_crlf();
        rstn = 1'b1;
        send_frame(29'h456, 1'b0, 64'h1000_0000_0000_0000, 1);
        wait_drain("drain_post_rst");
        repeat (5) @(negedge clk);
        check(o_tvalid == 1'b0, "post_rst_idle", o_tvalid, 0);
        check(drop_cnt == '0, "post_rst_drop", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
